// File: rtl/demux_pkg.sv
// Shared constants and the select decoder for the demux4_4b_seq slice.
// The optional auto-scan feature is enabled by defining DEMUX_AUTOSCAN_EN.
package demux_pkg;

    localparam int DEMUX_WIDTH   = 4;
    localparam int DEMUX_NUM_OUT = 4;
    localparam int SEL_W         = 2;
    localparam int XCNT_W        = 8;

    // One-hot decode of a channel select, used to steer the load strobe.
    function automatic logic [DEMUX_NUM_OUT-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [DEMUX_NUM_OUT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a demux channel: a load wins over a consume,
// so a same-cycle consume and refill keeps the slot valid with no bubble.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_consume,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Data is only written on load; it is left untouched after a consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux4_4b_seq.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready handshakes.
// Define DEMUX_AUTOSCAN_EN to add scan_en and a round-robin select pointer.
module demux4_4b_seq
    import demux_pkg::*;
#(
    parameter int WIDTH   = DEMUX_WIDTH,
    parameter int NUM_OUT = DEMUX_NUM_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef DEMUX_AUTOSCAN_EN
    input  logic               scan_en,
`endif
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   control,
    output logic [WIDTH-1:0]   out0,
    output logic [WIDTH-1:0]   out1,
    output logic [WIDTH-1:0]   out2,
    output logic [WIDTH-1:0]   out3,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [XCNT_W-1:0]  xfer_count
);

    logic [SEL_W-1:0]   w_sel;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_load;
    logic [NUM_OUT-1:0] w_consume;
    logic [NUM_OUT-1:0] w_valid;
    logic [WIDTH-1:0]   w_slot_data [NUM_OUT];
    logic [XCNT_W-1:0]  r_xfer_count;

`ifdef DEMUX_AUTOSCAN_EN
    logic [SEL_W-1:0]   r_scan_ptr;

    // The pointer only moves on accepts made while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_ptr <= '0;
        end else if (w_accept && scan_en) begin
            r_scan_ptr <= r_scan_ptr + SEL_W'(1);
        end
    end

    assign w_sel = scan_en ? r_scan_ptr : control;
`else
    assign w_sel = control;
`endif

    // A full slot can still accept when its consumer drains it this cycle.
    assign in_ready  = ~w_valid[w_sel] | out_ready[w_sel];
    assign w_accept  = in_valid & in_ready;
    assign w_load    = sel_decode(w_sel) & {NUM_OUT{w_accept}};
    assign w_consume = w_valid & out_ready;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (w_load[gi]),
            .i_consume (w_consume[gi]),
            .i_data    (in_data),
            .o_data    (w_slot_data[gi]),
            .o_valid   (w_valid[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_accept) begin
            r_xfer_count <= r_xfer_count + XCNT_W'(1);
        end
    end

    assign out0       = w_slot_data[0];
    assign out1       = w_slot_data[1];
    assign out2       = w_slot_data[2];
    assign out3       = w_slot_data[3];
    assign out_valid  = w_valid;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_demux4_4b_seq.sv
// Self-checking bench for demux4_4b_seq: vector table, per-channel scoreboard
// queues and hand-written reset, wrap and (with DEMUX_AUTOSCAN_EN) scan sequences.
module tb_demux4_4b_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] control = 2'd0;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'h0;
    logic [7:0] xfer_count;
`ifdef DEMUX_AUTOSCAN_EN
    logic       scan_en = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] sbq [4][$];
    logic [3:0] mValid = 4'h0;
    logic [7:0] mCount = 8'd0;
    logic [1:0] mPtr   = 2'd0;

    typedef struct {
        logic       vIn;
        logic [1:0] ctrl;
        logic [3:0] data;
        logic [3:0] rdy;
        logic       expReady;
        logic [3:0] expValid;
        logic [7:0] expCount;
    } vec_t;

    vec_t vecs [11];

    demux4_4b_seq #(
        .WIDTH   (4),
        .NUM_OUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DEMUX_AUTOSCAN_EN
        .scan_en    (scan_en),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .control    (control),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] outWord(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    task automatic modelReset();
        mValid = 4'h0;
        mCount = 8'd0;
        mPtr   = 2'd0;
        for (int i = 0; i < 4; i++) sbq[i].delete();
    endtask

    // Called at the falling edge: compare DUT against the model, then advance
    // the model to the state the coming rising edge should produce.
    task automatic scoreboardStep();
        logic [1:0] s;
        logic       r;
        s = control;
`ifdef DEMUX_AUTOSCAN_EN
        if (scan_en) s = mPtr;
`endif
        r = !mValid[s] || out_ready[s];
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, r});
        checkOutput("out_valid", {28'b0, out_valid}, {28'b0, mValid});
        checkOutput("xfer_count", {24'b0, xfer_count}, {24'b0, mCount});
        for (int i = 0; i < 4; i++) begin
            if (mValid[i]) checkOutput($sformatf("out%0d", i), {28'b0, outWord(i)}, {28'b0, sbq[i][0]});
        end
        for (int i = 0; i < 4; i++) begin
            if (mValid[i] && out_ready[i]) begin
                void'(sbq[i].pop_front());
                mValid[i] = 1'b0;
            end
        end
        if (in_valid && r) begin
            sbq[s].push_back(in_data);
            mValid[s] = 1'b1;
            mCount++;
`ifdef DEMUX_AUTOSCAN_EN
            if (scan_en) mPtr++;
`endif
        end
    endtask

    task automatic stepClock();
        @(negedge clk);
        scoreboardStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vIn, input logic [1:0] ctrl,
                                 input logic [3:0] data, input logic [3:0] rdy);
        in_valid  = vIn;
        control   = ctrl;
        in_data   = data;
        out_ready = rdy;
        stepClock();
    endtask

    // Assert reset between clock edges and check outputs clear without a clock.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst out0", {28'b0, out0}, 32'h0);
        checkOutput("rst out1", {28'b0, out1}, 32'h0);
        checkOutput("rst out2", {28'b0, out2}, 32'h0);
        checkOutput("rst out3", {28'b0, out3}, 32'h0);
        checkOutput("rst out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("rst xfer_count", {24'b0, xfer_count}, 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 8'd1};
        vecs[1]  = '{1'b0, 2'd0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 8'd1};
        vecs[2]  = '{1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1, 4'b0010, 8'd2};
        vecs[3]  = '{1'b1, 2'd2, 4'b1111, 4'b0000, 1'b1, 4'b0110, 8'd3};
        vecs[4]  = '{1'b1, 2'd3, 4'b0011, 4'b0000, 1'b1, 4'b1110, 8'd4};
        vecs[5]  = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 8'd4};
        vecs[6]  = '{1'b1, 2'd2, 4'b1010, 4'b0000, 1'b0, 4'b1110, 8'd4};
        vecs[7]  = '{1'b1, 2'd1, 4'b1001, 4'b0000, 1'b0, 4'b1110, 8'd4};
        vecs[8]  = '{1'b1, 2'd2, 4'b1010, 4'b0100, 1'b1, 4'b1110, 8'd5};
        vecs[9]  = '{1'b0, 2'd0, 4'b0000, 4'b1110, 1'b1, 4'b0000, 8'd5};
        vecs[10] = '{1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 4'b0000, 8'd5};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("init out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("init xfer_count", {24'b0, xfer_count}, 32'h0);
        checkOutput("init out0", {28'b0, out0}, 32'h0);
        checkOutput("init in_ready", {31'b0, in_ready}, 32'h1);
        modelReset();
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            in_valid  = vecs[k].vIn;
            control   = vecs[k].ctrl;
            in_data   = vecs[k].data;
            out_ready = vecs[k].rdy;
            @(negedge clk);
            checkOutput($sformatf("vec%0d in_ready", k), {31'b0, in_ready}, {31'b0, vecs[k].expReady});
            scoreboardStep();
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d out_valid", k), {28'b0, out_valid}, {28'b0, vecs[k].expValid});
            checkOutput($sformatf("vec%0d xfer_count", k), {24'b0, xfer_count}, {24'b0, vecs[k].expCount});
        end

        checkOutput("stale out0", {28'b0, out0}, 32'h5);
        checkOutput("stale out1", {28'b0, out1}, 32'h0);
        checkOutput("stale out2", {28'b0, out2}, 32'hA);
        checkOutput("stale out3", {28'b0, out3}, 32'h3);

        applyStimulus(1'b1, 2'd0, 4'h9, 4'h0);
        applyStimulus(1'b1, 2'd1, 4'h6, 4'h0);
        applyStimulus(1'b1, 2'd2, 4'hC, 4'h0);
        applyStimulus(1'b1, 2'd3, 4'h7, 4'h0);
        checkOutput("full out_valid", {28'b0, out_valid}, 32'hF);
        in_valid = 1'b0;
        asyncReset();
        in_valid = 1'b1;
        control  = 2'd2;
        in_data  = 4'hE;
        @(negedge clk);
        checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'h1);
        scoreboardStep();
        @(posedge clk);
        #1;
        checkOutput("post-reset out2", {28'b0, out2}, 32'hE);

`ifdef DEMUX_AUTOSCAN_EN
        scan_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 2'd3, 4'(k + 1), 4'hF);
            checkOutput($sformatf("scan%0d out_valid", k), {28'b0, out_valid}, 32'(1 << (k % 4)));
            checkOutput($sformatf("scan%0d data", k), {28'b0, outWord(k % 4)}, 32'(k + 1));
        end
        scan_en = 1'b0;
`endif

        in_valid = 1'b0;
        asyncReset();
        for (int k = 0; k < 255; k++) begin
            applyStimulus(1'b1, 2'(k % 4), 4'($urandom_range(0, 15)), 4'hF);
        end
        checkOutput("count 255", {24'b0, xfer_count}, 32'd255);
        applyStimulus(1'b1, 2'd1, 4'h3, 4'hF);
        checkOutput("count wrap", {24'b0, xfer_count}, 32'd0);
        applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux4_4b_seq.md
DEMUX4_4B_SEQ -- requirements
Module: demux4_4b_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of the input and of each output.
REQ-002 SHALL have parameter NUM_OUT, fixed at 4, number of output channels (select width 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  word to distribute.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 control  input  2  target channel select, sampled only on an accepted transfer.
REQ-009 out0..out3  output  WIDTH each  registered channel data.
REQ-010 out_valid  output  4  bit i: out<i> holds an unconsumed word.
REQ-011 out_ready  input  4  bit i: consumer of channel i takes out<i> this cycle.
REQ-012 xfer_count  output  8  number of accepted input transfers, modulo 256.

Function
REQ-013 Accept = in_valid & in_ready, evaluated at the rising edge.
REQ-014 in_ready = ~out_valid[sel] | out_ready[sel], combinational; sel = control, or scan pointer per REQ-025.
REQ-015 On accept, in_data SHALL load into slot sel and out_valid[sel] SHALL be 1 the next cycle (latency 1).
REQ-016 Channel i consume = out_valid[i] & out_ready[i]; on consume without refill, out_valid[i] SHALL clear next cycle.
REQ-017 Simultaneous consume and accept on the same slot SHALL replace the data and keep out_valid[i] = 1, with no bubble.
REQ-018 out<i> SHALL hold its value while out_valid[i] = 1 and out_ready[i] = 0; non-selected slots SHALL be unaffected.
REQ-019 out<i> SHALL keep its last value after consume; only out_valid qualifies it.
REQ-020 out_ready with out_valid = 0 SHALL have no effect.
REQ-021 Each accept SHALL increment xfer_count; 255 SHALL wrap to 0.
REQ-022 control changes while in_valid = 1 and in_ready = 0 are legal; a later accept uses control as sampled in the accepting cycle.

Reset
REQ-023 On rst_n low, asynchronously: out0..out3 = 0, out_valid = 4'b0000, xfer_count = 0, scan pointer = 0.
REQ-024 Reset mid-operation SHALL discard all held words; the first cycle after release SHALL have in_ready = 1.

Configuration
REQ-025 With DEMUX_AUTOSCAN_EN defined: extra input scan_en (1 bit); when scan_en = 1, sel = internal 2-bit pointer and control is ignored; pointer advances 0->1->2->3->0 on each accept; pointer holds when scan_en = 0.
REQ-026 Without DEMUX_AUTOSCAN_EN: no scan_en port, no pointer; sel = control always.

Structure
REQ-027 Package demux_pkg SHALL hold WIDTH default, NUM_OUT, SEL_W = 2, and XCNT_W = 8.
REQ-028 One sub-module, demux_slot: a one-entry holding register with load, consume, data and valid; the top SHALL instantiate it 4 times.

Verification
REQ-029 Reset, then in_data = 4'b0101, control = 00, in_valid pulse with out_ready = 1111 -> out0 = 0101, out_valid = 0001 for 1 cycle, xfer_count = 1.
REQ-030 Sequence 0000@01, 1111@10, 0011@11 with out_ready = 0000 -> out1 = 0000, out2 = 1111, out3 = 0011, out_valid = 1110, each held.
REQ-031 Slot 2 full, out_ready = 0000, control = 10, in_valid = 1 -> in_ready = 0, out2 stays 1111; raise out_ready[2] -> accept and replace in the same cycle, out_valid[2] stays 1.
REQ-032 256 accepts -> xfer_count returns to 0.
REQ-033 DEMUX_AUTOSCAN_EN, scan_en = 1, words 1,2,3,4,5 with out_ready = 1111 -> landing on out0, out1, out2, out3, out0; control ignored.
REQ-034 rst_n low with out_valid = 1111 -> all outputs 0 immediately (before the next clk edge), in_ready = 1 after release.
